// File: rtl/axi_lite_master_arb.sv
// axi_lite_master_arb
//   Shares one AXI4-Lite master port among N single-beat requesters. One
//   command at a time is granted, run through AR/R or AW+W/B, and its response
//   is returned to the owner as a one-cycle rsp_valid pulse.
//
// Build option:
//   AXIL_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                           undefined -> round-robin (default)
//
// Ports:
//   aclk, areset                  clock, asynchronous active-high reset
//   req_valid/write/addr/wdata/wstrb  packed per-requester command inputs
//   req_ready                     one-cycle accept pulse to the winner
//   rsp_valid/rdata/resp          completion pulse, read data, RRESP/BRESP
//   busy                          accept through response cycle
//   m_aw*/m_w*/m_b*/m_ar*/m_r*    AXI4-Lite master channels
module axi_lite_master_arb #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N-1:0]               req_valid,
  input  logic [N-1:0]               req_write,
  input  logic [N*ADDR_W-1:0]        req_addr,
  input  logic [N*DATA_W-1:0]        req_wdata,
  input  logic [N*(DATA_W/8)-1:0]    req_wstrb,
  output logic [N-1:0]               req_ready,
  output logic [N-1:0]               rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic                       busy,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic [ADDR_W-1:0]          m_araddr,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rvalid,
  output logic                       m_rready
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     g_q, g_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                write_q, write_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_found;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last (winning) write.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[IdxW'(k)]) begin
        gnt_idx   = IdxW'(k);
        gnt_found = 1'b1;
      end
    end
  end
`else
  logic [IdxW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps; first hit wins.
  always_comb begin
    int unsigned idx;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!gnt_found && req_valid[IdxW'(idx)]) begin
        gnt_idx   = IdxW'(idx);
        gnt_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
`ifndef AXIL_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          g_d       = gnt_idx;
          addr_d    = req_addr[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d   = req_wdata[gnt_idx*DATA_W +: DATA_W];
          wstrb_d   = req_wstrb[gnt_idx*StrbW +: StrbW];
          write_d   = req_write[gnt_idx];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write[gnt_idx] ? StWreq : StRaddr;
`ifndef AXIL_ARB_FIXED_PRIO_EN
          ptr_d     = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
      end
      StRaddr: if (m_arready) state_d = StRdata;
      StRdata: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          resp_d  = m_rresp;
          state_d = StResp;
        end
      end
      StWreq: begin
        // AW and W complete independently, possibly in the same cycle.
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (m_wvalid && m_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)  state_d   = StWresp;
      end
      StWresp: begin
        if (m_bvalid) begin
          resp_d  = m_bresp;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      g_q       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  // Master outputs decode registered state only.
  assign m_arvalid = (state_q == StRaddr);
  assign m_araddr  = m_arvalid ? addr_q : '0;
  assign m_rready  = (state_q == StRdata);
  assign m_awvalid = (state_q == StWreq) && !aw_done_q;
  assign m_awaddr  = m_awvalid ? addr_q : '0;
  assign m_wvalid  = (state_q == StWreq) && !w_done_q;
  assign m_wdata   = m_wvalid ? wdata_q : '0;
  assign m_wstrb   = m_wvalid ? wstrb_q : '0;
  assign m_bready  = (state_q == StWresp);

  // Accept is combinational from req_valid; gated so reset forces it low.
  assign req_ready = (state_q == StIdle && gnt_found && !areset) ? (N'(1) << gnt_idx) : '0;
  assign busy      = !areset && ((state_q != StIdle) || gnt_found);
  assign rsp_valid = (state_q == StResp) ? (N'(1) << g_q) : '0;
  assign rsp_rdata = (state_q == StResp && !write_q) ? rdata_q : '0;
  assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axi_lite_master_arb.sv
// Directed self-checking bench for axi_lite_master_arb (N=4, ADDR_W=12, DATA_W=32).
// Inputs are driven 1 time unit after the rising edge and outputs sampled there
// (plus #1 after any input change, for combinational paths).
module tb_axi_lite_master_arb;

  localparam int unsigned N = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic              aclk;
  logic              areset;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*DW/8-1:0] req_wstrb;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              busy;
  logic [AW-1:0]     m_awaddr, m_araddr;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW-1:0]     m_wdata, m_rdata;
  logic [DW/8-1:0]   m_wstrb;
  logic [1:0]        m_bresp, m_rresp;
  logic              m_arvalid, m_arready, m_rvalid, m_rready;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;
  logic [N-1:0] rr_exp [5];

  axi_lite_master_arb #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic slave_idle();
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    areset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    slave_idle();
    tick(); tick();
    check("rst_ctl", {req_ready, rsp_valid, busy, m_arvalid, m_awvalid, m_wvalid,
                      m_bready, m_rready}, 0);
    check("rst_data", {rsp_rdata, rsp_resp, m_araddr, m_awaddr}, 0);
    check("rst_wdata", {m_wdata, m_wstrb}, 0);
    areset = 0;
    tick();

    // Round-robin with all requesters continuously valid, zero-wait slave.
`ifdef AXIL_ARB_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    m_arready = 1; m_rvalid = 1; m_rdata = 32'hA5A5_5A5A;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      cnt = 0;
      while (req_ready == 0 && cnt < 10) begin tick(); cnt++; end
      check($sformatf("rr_grant%0d", i), req_ready, rr_exp[i]);
      tick();
    end
    req_valid = 0;
    cnt = 0;
    while (busy && cnt < 10) begin tick(); cnt++; end
    check("rr_drain", busy, 0);
    slave_idle();
    tick();

    // Single read from requester 2, zero-wait slave.
    m_arready = 1; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 0;
    req_addr[2*AW +: AW] = 12'h040; req_write = 0; req_valid = 4'b0100;
    #1;
    check("rd_ready", req_ready, 4'b0100);
    check("rd_busy0", busy, 1);
    tick(); req_valid = 0;                                   // cycle 1
    check("rd_arvalid", m_arvalid, 1);
    check("rd_araddr", m_araddr, 12'h040);
    tick();                                                  // cycle 2
    check("rd_rready", {m_arvalid, m_rready}, 2'b01);
    check("rd_araddr_idle", m_araddr, 0);
    tick();                                                  // cycle 3
    check("rd_rsp_valid", rsp_valid, 4'b0100);
    check("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_resp", rsp_resp, 0);
    check("rd_busy3", busy, 1);
    tick();                                                  // cycle 4
    check("rd_rsp_done", {rsp_valid, busy}, 0);
    slave_idle();

    // Write from requester 1; W accepted two cycles before AW.
    req_addr[1*AW +: AW] = 12'h3A8; req_wdata[1*DW +: DW] = 32'h1234_5678;
    req_wstrb[1*4 +: 4] = 4'hF; req_write = 4'b0010; req_valid = 4'b0010;
    m_wready = 1;
    #1;
    check("wr_ready", req_ready, 4'b0010);
    tick(); req_valid = 0;                                   // cycle 1
    check("wr_valids1", {m_awvalid, m_wvalid}, 2'b11);
    check("wr_wdata", m_wdata, 32'h1234_5678);
    check("wr_wstrb", m_wstrb, 4'hF);
    check("wr_awaddr", m_awaddr, 12'h3A8);
    tick(); m_wready = 0;                                    // cycle 2
    check("wr_valids2", {m_awvalid, m_wvalid}, 2'b10);
    check("wr_wdata_idle", m_wdata, 0);
    tick(); m_awready = 1;                                   // cycle 3
    check("wr_valids3", {m_awvalid, m_wvalid, m_bready}, 3'b100);
    tick(); m_awready = 0; m_bvalid = 1; m_bresp = 2'b01;    // cycle 4
    check("wr_bready", {m_awvalid, m_wvalid, m_bready}, 3'b001);
    tick(); m_bvalid = 0;                                    // cycle 5
    check("wr_rsp_valid", rsp_valid, 4'b0010);
    check("wr_rdata", rsp_rdata, 0);
    check("wr_resp", rsp_resp, 2'b01);
    tick();                                                  // cycle 6
    check("wr_rsp_once", rsp_valid, 0);
    slave_idle();

    // Read from requester 3 with 5 AR wait cycles and SLVERR.
    req_addr[3*AW +: AW] = 12'h7FC; req_write = 0; req_valid = 4'b1000;
    m_rresp = 2'b10; m_rdata = 32'h1111_2222;
    #1;
    check("slv_ready", req_ready, 4'b1000);
    tick(); req_valid = 0;
    for (int w = 1; w <= 5; w++) begin
      check($sformatf("slv_ar_wait%0d", w), {m_arvalid, m_araddr}, {1'b1, 12'h7FC});
      tick();
    end
    m_arready = 1;                                           // cycle 6
    check("slv_ar_hs", {m_arvalid, m_araddr}, {1'b1, 12'h7FC});
    tick(); m_arready = 0; m_rvalid = 1;                     // cycle 7
    check("slv_rready", {m_arvalid, m_rready}, 2'b01);
    tick(); m_rvalid = 0;                                    // cycle 8
    check("slv_rsp_valid", rsp_valid, 4'b1000);
    check("slv_resp", rsp_resp, 2'b10);
    check("slv_rdata", rsp_rdata, 32'h1111_2222);
    tick();
    slave_idle();

    // Reset during RDATA aborts; pointer restarts at 0.
    req_addr[0 +: AW] = 12'h100; req_valid = 4'b0001; m_arready = 1;
    #1;
    check("ab_ready", req_ready, 4'b0001);
    tick(); req_valid = 0;
    tick();
    check("ab_in_rdata", {m_rready, busy}, 2'b11);
    areset = 1;
    #1;
    check("ab_drop", {m_rready, busy, m_arvalid, rsp_valid}, 0);
    tick(); tick();
    check("ab_no_rsp", rsp_valid, 0);
    areset = 0;
    m_rvalid = 1; m_rdata = 32'h0BAD_F00D; m_rresp = 0;
    req_addr[3*AW +: AW] = 12'h200; req_valid = 4'b1001;
    #1;
    check("ab_ptr_restart", req_ready, 4'b0001);
    tick(); req_valid = 0;                                   // cycle 1
    check("ab_araddr", m_araddr, 12'h100);
    tick();                                                  // cycle 2
    tick();                                                  // cycle 3
    check("ab_rsp_valid", rsp_valid, 4'b0001);
    check("ab_rdata", rsp_rdata, 32'h0BAD_F00D);
    tick();
    check("ab_idle", busy, 0);
    slave_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_arb.md
# axi_lite_master_arb

Sequencer and round-robin arbiter that shares one AXI4-Lite master port among N simple requesters in the AXI4-Lite interconnect. Each requester presents a single-beat read or write command. The block grants one command at a time, runs the full AXI4-Lite handshake sequence (AR/R or AW+W/B), and returns the read data and response to the granted requester. It sits between local client logic and the interconnect's master-side channel set.

## Interface
- N, 4, number of requesters (2..8)
- ADDR_W, 12, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- aclk  in  1  clock; all logic rises on posedge
- areset  in  1  asynchronous, active-high reset
- req_valid  in  N  per-requester command valid; held until req_ready
- req_write  in  N  1 = write, 0 = read
- req_addr  in  N*ADDR_W  requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  N*DATA_W  write data, same packing
- req_wstrb  in  N*DATA_W/8  write strobes, same packing
- req_ready  out  N  one-cycle accept pulse to the granted requester
- rsp_valid  out  N  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid; 0 for writes
- rsp_resp  out  2  RRESP or BRESP of the completed transaction
- busy  out  1  high from accept until the rsp_valid cycle inclusive
- m_awaddr/m_awvalid out, m_awready in  AW channel
- m_wdata/m_wstrb/m_wvalid out, m_wready in  W channel
- m_bresp/m_bvalid in, m_bready out  B channel
- m_araddr/m_arvalid out, m_arready in  AR channel
- m_rdata/m_rresp/m_rvalid in, m_rready out  R channel

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, RESP.
- IDLE: if any req_valid is high, the arbiter picks winner g combinationally and pulses req_ready[g]. It latches addr, wdata, wstrb, write, and g. Next state is RADDR (read) or WREQ (write). The round-robin pointer moves to g+1 mod N.
- Round-robin: the search starts at the pointer and wraps. After reset the pointer is 0.
- RADDR: m_arvalid=1, m_araddr=latched addr. On m_arready, go to RDATA.
- RDATA: m_rready=1. On m_rvalid, capture m_rdata and m_rresp, then go to RESP.
- WREQ: m_awvalid and m_wvalid are asserted together. Each drops independently after its own handshake (tracked by aw_done and w_done flags). Once both are done, go to WRESP. A same-cycle AW and W handshake is legal.
- WRESP: m_bready=1. On m_bvalid, capture m_bresp, set rdata to 0, then go to RESP.
- RESP: rsp_valid[g]=1 for exactly one cycle; the response has no backpressure. Next state is IDLE.
- When its valid is low, m_araddr, m_awaddr, m_wdata and m_wstrb are driven to 0.
- Requests arriving in non-IDLE states wait and are not dropped. Only one transaction is outstanding.

## Timing
- Reset: all outputs are 0, state is IDLE, the pointer is 0, and the latched registers are 0.
- Asserting areset mid-transaction aborts immediately; all valid and ready outputs drop asynchronously. No response is issued for the aborted command.
- Read with zero-wait slave: accept at cycle 0, m_arvalid at cycle 1, m_rready at cycle 2, rsp_valid at cycle 3. The next accept is possible at cycle 4.
- Write with zero-wait slave: accept at 0, AW and W at 1, m_bready at 2, rsp_valid at 3.
- Each slave wait cycle on any channel adds one cycle. The state is held and master valids stay stable until their handshake completes.
- req_ready is combinational from req_valid in IDLE. All m_* outputs are registered or decoded from registered state only.

## Configuration
- AXIL_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest index wins and the pointer logic is removed.
- AXIL_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Single read from requester 2 at addr 0x040 with m_rdata=0xDEADBEEF and zero-wait slave -> m_araddr=0x040 at cycle 1; rsp_valid=4'b0100, rsp_rdata=0xDEADBEEF, rsp_resp=0 at cycle 3.
- Write from requester 1 with wdata=0x12345678 and wstrb=0xF; slave accepts W 2 cycles before AW -> m_wvalid drops after W handshake while m_awvalid holds; bready follows; rsp_valid[1] pulses once, rsp_rdata=0.
- All 4 requesters hold req_valid continuously -> grant order is 0,1,2,3,0. With AXIL_ARB_FIXED_PRIO_EN defined, the order is 0,0,0 while req 0 stays valid.
- Slave returns RRESP=2'b10 after 5 wait cycles -> m_arvalid is stable during the wait; rsp_resp=2'b10.
- areset asserted during RDATA -> m_rready and busy drop in the same cycle; after release, a new request completes normally and the pointer restarts at 0.
